bsg_mesh_router_output_alloc: RTL and testbench

Per-output-port wormhole allocator for the mesh/ruche router. It consumes the one-hot `req_o` vectors from the input-side dimension-ordered decoders, restricted to the bit for this output. It arbitrates round-robin among input FIFOs whose head flit requests this output, then locks the grant for the packet's length. It also tracks downstream credits. One instance sits per output direction, driving the crossbar select and the output link valid.

---
 rtl/bsg_mesh_router_output_alloc.sv | 108 ++++++++++
 tb/tb_bsg_mesh_router_output_alloc.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bsg_mesh_router_output_alloc.sv
// bsg_mesh_router_output_alloc: per-output wormhole allocator with round-robin header arbitration and credit tracking
// Ports:
//   clk_i      - clock
//   reset_i    - asynchronous active-low reset
//   v_i        - per-input head flit valid
//   req_i      - per-input request for this output (meaningful on headers)
//   len_i      - per-input body-flit count, input k at [k*len_width_p +: len_width_p]
//   yumi_o     - one-hot dequeue strobe to the sending input
//   sel_o      - one-hot crossbar select (current or last grant)
//   v_o        - flit sent downstream this cycle
//   credit_i   - downstream returned one buffer slot
//   credits_o  - current credit count
module bsg_mesh_router_output_alloc #(
   parameter int inputs_p    = 5,
   parameter int len_width_p = 4,
   parameter int credits_p   = 4,
   localparam int iw = (inputs_p > 1) ? $clog2(inputs_p) : 1,
   localparam int cw = $clog2(credits_p + 1)
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [inputs_p-1:0]             v_i,
   input  logic [inputs_p-1:0]             req_i,
   input  logic [inputs_p*len_width_p-1:0] len_i,
   output logic [inputs_p-1:0]             yumi_o,
   output logic [inputs_p-1:0]             sel_o,
   output logic                            v_o,
   input  logic                            credit_i,
   output logic [cw-1:0]                   credits_o
);
   typedef enum logic {IDLE, LOCKED} state_e;
   state_e                 state_q, state_n;
   logic [iw-1:0]          owner_q, owner_n, last_q, last_n, grant, idx;
   logic [len_width_p-1:0] remain_q, remain_n, len_g;
   logic [cw-1:0]          credits_q, credits_n;
   logic [inputs_p-1:0]    cand;
   logic                   found, has_cr;
   // Scan from the lowest priority to the highest so the last hit wins,
   // leaving the first candidate at or after last_q+1 as the grant.
   always_comb begin
      cand  = v_i & req_i;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = inputs_p; k >= 1; k--) begin
         idx = iw'((int'(last_q) + k) % inputs_p);
         if (cand[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
      len_g = len_i[int'(grant)*len_width_p +: len_width_p];
   end
   // Outputs are forced idle while reset is held, since the candidate
   // path is combinational from the inputs.
   always_comb begin
      has_cr = credits_q != '0;
      v_o    = reset_i && has_cr && ((state_q == IDLE) ? found : v_i[owner_q]);
      sel_o  = !reset_i ? '0
             : (state_q == LOCKED) ? inputs_p'(1) << owner_q
             : v_o ? inputs_p'(1) << grant : '0;
      yumi_o = v_o ? sel_o : '0;
   end
   always_comb begin
      state_n  = state_q;
      owner_n  = owner_q;
      remain_n = remain_q;
      last_n   = last_q;
      if (v_o && state_q == IDLE) begin
         last_n = grant;
         if (len_g != '0) begin
            state_n  = LOCKED;
            owner_n  = grant;
            remain_n = len_g;
         end
      end
      if (v_o && state_q == LOCKED) begin
         remain_n = remain_q - len_width_p'(1);
         state_n  = (remain_q == len_width_p'(1)) ? IDLE : LOCKED;
      end
      // An overflowing credit return saturates rather than wrapping.
      credits_n = (credit_i && !v_o && credits_q == cw'(credits_p)) ? credits_q
                : credits_q + cw'(credit_i) - cw'(v_o);
   end
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         remain_q  <= '0;
         last_q    <= iw'(inputs_p - 1);
         credits_q <= cw'(credits_p);
      end else begin
         state_q   <= state_n;
         owner_q   <= owner_n;
         remain_q  <= remain_n;
         last_q    <= last_n;
         credits_q <= credits_n;
      end
   end
   assign credits_o = credits_q;
`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (reset_i)
         assert (!(credit_i && !v_o && credits_q == cw'(credits_p)))
            else $error("credit overflow at count %0d", credits_q);
   end
`endif
endmodule

// File: tb/tb_bsg_mesh_router_output_alloc.sv
// tb_bsg_mesh_router_output_alloc: directed scoreboard bench for the output allocator
module tb_bsg_mesh_router_output_alloc;
   localparam int N  = 5;
   localparam int LW = 4;
   localparam int CP = 4;
   localparam int CW = $clog2(CP + 1);
   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [N-1:0]  v_i, req_i, yumi_o, sel_o;
   logic [N*LW-1:0] len_i;
   logic          v_o, credit_i;
   logic [CW-1:0] credits_o;
   typedef struct {
      logic       v;
      logic [4:0] y;
      logic [4:0] s;
      int         c;
      string      tag;
   } exp_t;
   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   ec = CP;
   bsg_mesh_router_output_alloc #(.inputs_p(N), .len_width_p(LW), .credits_p(CP)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .req_i(req_i), .len_i(len_i),
      .yumi_o(yumi_o), .sel_o(sel_o), .v_o(v_o), .credit_i(credit_i), .credits_o(credits_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic check();
      exp_t e;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty got none exp entry");
         return;
      end
      e = sb.pop_front();
      vectors++;
      assert (v_o === e.v) else begin
         miscompares++;
         $error("FAIL %s v_o got %b exp %b", e.tag, v_o, e.v);
      end
      assert (yumi_o === e.y) else begin
         miscompares++;
         $error("FAIL %s yumi_o got %b exp %b", e.tag, yumi_o, e.y);
      end
      assert (sel_o === e.s) else begin
         miscompares++;
         $error("FAIL %s sel_o got %b exp %b", e.tag, sel_o, e.s);
      end
      assert (credits_o === CW'(e.c)) else begin
         miscompares++;
         $error("FAIL %s credits_o got %0d exp %0d", e.tag, credits_o, e.c);
      end
   endtask
   task automatic step(input logic [4:0] v, input logic [4:0] r, input logic [19:0] l,
                       input logic cr, input logic ev, input logic [4:0] ey,
                       input logic [4:0] es, input string tag);
      v_i = v;
      req_i = r;
      len_i = l;
      credit_i = cr;
      sb.push_back('{ev, ey, es, ec, tag});
      @(negedge clk_i);
      check();
      ec = ec + int'(cr) - int'(ev);
      if (ec > CP) ec = CP;
      @(posedge clk_i);
      #1;
   endtask
   initial begin
      reset_i = 1'b0;
      v_i = 5'b10101;
      req_i = 5'b10101;
      len_i = '0;
      credit_i = 1'b0;
      @(negedge clk_i);
      sb.push_back('{1'b0, 5'b0, 5'b0, CP, "reset"});
      check();
      @(posedge clk_i);
      #1 reset_i = 1'b1;
      // three single-flit requesters after reset: 0, 2, 4
      step(5'b10101, 5'b10101, 20'h0, 0, 1, 5'b00001, 5'b00001, "rr_0");
      step(5'b10101, 5'b10101, 20'h0, 0, 1, 5'b00100, 5'b00100, "rr_2");
      step(5'b10101, 5'b10101, 20'h0, 0, 1, 5'b10000, 5'b10000, "rr_4");
      step(5'b00000, 5'b00000, 20'h0, 1, 0, 5'b0, 5'b0, "refill_1");
      step(5'b00000, 5'b00000, 20'h0, 1, 0, 5'b0, 5'b0, "refill_2");
      step(5'b00000, 5'b00000, 20'h0, 1, 0, 5'b0, 5'b0, "refill_3");
      // input 1 len=3 locks out input 3; len changes after header are ignored
      step(5'b01010, 5'b01010, {4'd0, 4'd0, 4'd0, 4'd3, 4'd0}, 1, 1, 5'b00010, 5'b00010, "lock_hdr");
      step(5'b01010, 5'b01010, {4'd0, 4'd0, 4'd0, 4'd15, 4'd0}, 1, 1, 5'b00010, 5'b00010, "lock_b1");
      step(5'b01010, 5'b01010, {4'd0, 4'd0, 4'd0, 4'd15, 4'd0}, 1, 1, 5'b00010, 5'b00010, "lock_b2");
      step(5'b01010, 5'b01010, {4'd0, 4'd0, 4'd0, 4'd15, 4'd0}, 1, 1, 5'b00010, 5'b00010, "lock_b3");
      step(5'b01000, 5'b01000, 20'h0, 1, 1, 5'b01000, 5'b01000, "after_lock");
      // owner bubble: input 1 len=2, input 0 waiting must not interleave
      step(5'b00010, 5'b00010, {4'd0, 4'd0, 4'd0, 4'd2, 4'd0}, 0, 1, 5'b00010, 5'b00010, "bub_hdr");
      step(5'b00001, 5'b00001, 20'h0, 0, 0, 5'b0, 5'b00010, "bubble_1");
      step(5'b00001, 5'b00001, 20'h0, 0, 0, 5'b0, 5'b00010, "bubble_2");
      step(5'b00011, 5'b00011, 20'h0, 0, 1, 5'b00010, 5'b00010, "bub_b1");
      step(5'b00011, 5'b00011, 20'h0, 0, 1, 5'b00010, 5'b00010, "bub_b2");
      // credit exhaustion and return
      step(5'b00100, 5'b00100, 20'h0, 0, 1, 5'b00100, 5'b00100, "cr_last");
      step(5'b00100, 5'b00100, 20'h0, 1, 0, 5'b0, 5'b0, "cr_stall_ret");
      step(5'b00100, 5'b00100, 20'h0, 0, 1, 5'b00100, 5'b00100, "cr_next");
      step(5'b00100, 5'b00100, 20'h0, 0, 0, 5'b0, 5'b0, "cr_stall");
      step(5'b00100, 5'b00100, 20'h0, 1, 0, 5'b0, 5'b0, "cr_stall_ret2");
      step(5'b00100, 5'b00100, 20'h0, 1, 1, 5'b00100, 5'b00100, "cr_simul");
      step(5'b00000, 5'b00000, 20'h0, 1, 0, 5'b0, 5'b0, "cr_fill_a");
      step(5'b00000, 5'b00000, 20'h0, 1, 0, 5'b0, 5'b0, "cr_fill_b");
      step(5'b00000, 5'b00000, 20'h0, 1, 0, 5'b0, 5'b0, "cr_fill_c");
      // fairness: last grant was 2, so rotation starts at 3
      for (int i = 0; i < 10; i++) begin
         logic [4:0] g;
         g = 5'b00001 << ((3 + i) % 5);
         step(5'b11111, 5'b11111, 20'h0, 1, 1, g, g, "fair");
      end
      // mid-packet async reset with remain=2
      step(5'b01001, 5'b01001, {4'd0, 4'd3, 4'd0, 4'd0, 4'd0}, 0, 1, 5'b01000, 5'b01000, "rst_hdr");
      step(5'b01001, 5'b01001, {4'd0, 4'd3, 4'd0, 4'd0, 4'd0}, 0, 1, 5'b01000, 5'b01000, "rst_b1");
      reset_i = 1'b0;
      #2;
      ec = CP;
      sb.push_back('{1'b0, 5'b0, 5'b0, CP, "async_reset"});
      check();
      @(posedge clk_i);
      #1 reset_i = 1'b1;
      step(5'b01001, 5'b01001, {4'd0, 4'd3, 4'd0, 4'd0, 4'd0}, 0, 1, 5'b00001, 5'b00001, "post_rst_0");
      step(5'b01000, 5'b01000, 20'h0, 0, 1, 5'b01000, 5'b01000, "post_rst_3");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
